// File: rtl/huff_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// huff_pkg - shared Huffman node field widths, field helpers and sorter states
// Rev 1.0
// ----------------------------------------------------------------------------
package huff_pkg;

  localparam int KEY_W_DEF  = 8;
  localparam int TAG_W_DEF  = 5;
  localparam int NODE_W_DEF = KEY_W_DEF + TAG_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } sort_state_e;

  function automatic logic [KEY_W_DEF-1:0] node_key(input logic [NODE_W_DEF-1:0] node);
    return node[NODE_W_DEF-1:TAG_W_DEF];
  endfunction

  function automatic logic [TAG_W_DEF-1:0] node_tag(input logic [NODE_W_DEF-1:0] node);
    return node[TAG_W_DEF-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/huff_cmp_swap.sv
`default_nettype none
// ----------------------------------------------------------------------------
// huff_cmp_swap - combinational compare-exchange cell for one adjacent node pair
// Rev 1.0
// ----------------------------------------------------------------------------
module huff_cmp_swap
  import huff_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NODE_W = KEY_W + TAG_W
) (
  input  logic [NODE_W-1:0] lo_i,
  input  logic [NODE_W-1:0] hi_i,
  input  logic              lo_vld_i,
  input  logic              hi_vld_i,
  input  logic              desc_i,
  output logic [NODE_W-1:0] lo_o,
  output logic [NODE_W-1:0] hi_o,
  output logic              lo_vld_o,
  output logic              hi_vld_o
);

  logic [KEY_W-1:0] lo_key;
  logic [KEY_W-1:0] hi_key;
  logic             swap;

  assign lo_key = lo_i[NODE_W-1:TAG_W];
  assign hi_key = hi_i[NODE_W-1:TAG_W];

  // Strict key compares keep equal keys in input order.
  always_comb begin
    swap = 1'b0;
    if (!lo_vld_i && hi_vld_i) begin
      swap = 1'b1;
    end else if (lo_vld_i && hi_vld_i) begin
      swap = desc_i ? (lo_key < hi_key) : (lo_key > hi_key);
    end
  end

  assign lo_o     = swap ? hi_i : lo_i;
  assign hi_o     = swap ? lo_i : hi_i;
  assign lo_vld_o = swap ? hi_vld_i : lo_vld_i;
  assign hi_vld_o = swap ? lo_vld_i : hi_vld_i;

endmodule
`default_nettype wire

// File: rtl/huff_node_sorter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// huff_node_sorter - N-slot odd-even transposition sorter for Huffman nodes
// Rev 1.0
// ----------------------------------------------------------------------------
module huff_node_sorter
  import huff_pkg::*;
#(
  parameter int N      = 4,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int NODE_W = KEY_W + TAG_W,
  parameter int CNT_W  = $clog2(N + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                desc_i,
  input  logic [N*NODE_W-1:0] nodes_i,
  input  logic [N-1:0]        valid_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [N*NODE_W-1:0] nodes_o,
  output logic [N-1:0]        valid_o,
  output logic [CNT_W-1:0]    valid_cnt_o
);

  localparam int PH_W = $clog2(N);
  localparam int N_EV = N / 2;
  localparam int N_OD = (N - 1) / 2;

  sort_state_e         state_q;
  logic [NODE_W-1:0]   work_q [N];
  logic [N-1:0]        vld_q;
  logic                desc_q;
  logic [PH_W-1:0]     phase_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [N*NODE_W-1:0] out_nodes_q;
  logic [N-1:0]        out_vld_q;
  logic [CNT_W-1:0]    out_cnt_q;

  logic [NODE_W-1:0]   ev_n [N];
  logic [NODE_W-1:0]   od_n [N];
  logic                ev_v [N];
  logic                od_v [N];
  logic [NODE_W-1:0]   work_d [N];
  logic [N-1:0]        vld_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [N*NODE_W-1:0] masked_d;

  for (genvar i = 0; i < N_EV; i++) begin : g_even
    huff_cmp_swap #(.KEY_W(KEY_W), .TAG_W(TAG_W), .NODE_W(NODE_W)) u_cell (
      .lo_i(work_q[2*i]), .hi_i(work_q[2*i+1]),
      .lo_vld_i(vld_q[2*i]), .hi_vld_i(vld_q[2*i+1]), .desc_i(desc_q),
      .lo_o(ev_n[2*i]), .hi_o(ev_n[2*i+1]),
      .lo_vld_o(ev_v[2*i]), .hi_vld_o(ev_v[2*i+1])
    );
  end

  if (N % 2 == 1) begin : g_even_tail
    assign ev_n[N-1] = work_q[N-1];
    assign ev_v[N-1] = vld_q[N-1];
  end

  assign od_n[0] = work_q[0];
  assign od_v[0] = vld_q[0];

  for (genvar i = 0; i < N_OD; i++) begin : g_odd
    huff_cmp_swap #(.KEY_W(KEY_W), .TAG_W(TAG_W), .NODE_W(NODE_W)) u_cell (
      .lo_i(work_q[2*i+1]), .hi_i(work_q[2*i+2]),
      .lo_vld_i(vld_q[2*i+1]), .hi_vld_i(vld_q[2*i+2]), .desc_i(desc_q),
      .lo_o(od_n[2*i+1]), .hi_o(od_n[2*i+2]),
      .lo_vld_o(od_v[2*i+1]), .hi_vld_o(od_v[2*i+2])
    );
  end

  if (N % 2 == 0) begin : g_odd_tail
    assign od_n[N-1] = work_q[N-1];
    assign od_v[N-1] = vld_q[N-1];
  end

  always_comb begin
    cnt_d    = '0;
    masked_d = '0;
    vld_d    = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d     = cnt_d + CNT_W'(valid_i[i]);
      work_d[i] = phase_q[0] ? od_n[i] : ev_n[i];
      vld_d[i]  = phase_q[0] ? od_v[i] : ev_v[i];
      if (vld_q[i]) masked_d[i*NODE_W +: NODE_W] = work_q[i];
    end
  end

  // Accepting start in DONE overrides the return to IDLE, giving back-to-back sorts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      vld_q       <= '0;
      desc_q      <= 1'b0;
      phase_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_nodes_q <= '0;
      out_vld_q   <= '0;
      out_cnt_q   <= '0;
      for (int i = 0; i < N; i++) work_q[i] <= '0;
    end else begin
      busy_q <= (state_q == ST_SORT);
      done_q <= (state_q == ST_DONE);
      case (state_q)
        ST_SORT: begin
          for (int i = 0; i < N; i++) work_q[i] <= work_d[i];
          vld_q   <= vld_d;
          phase_q <= phase_q + 1'b1;
          if (phase_q == PH_W'(N - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          out_nodes_q <= masked_d;
          out_vld_q   <= vld_q;
          out_cnt_q   <= cnt_q;
          state_q     <= ST_IDLE;
        end
        default: ;
      endcase
      if (start_i && (state_q != ST_SORT)) begin
        for (int i = 0; i < N; i++) work_q[i] <= nodes_i[i*NODE_W +: NODE_W];
        vld_q   <= valid_i;
        desc_q  <= desc_i;
        cnt_q   <= cnt_d;
        phase_q <= '0;
        state_q <= ST_SORT;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign nodes_o     = out_nodes_q;
  assign valid_o     = out_vld_q;
  assign valid_cnt_o = out_cnt_q;

endmodule
`default_nettype wire
